// File: rtl/hp_damage_ctrl.sv
// Hit-point owner for both tanks: round-robin arbitration of hit requests, saturating damage,
// win/lose detection. Optional regeneration of our HP when HP_REGEN_EN is defined.
module hp_damage_ctrl #(
    parameter int HP_MAX       = 200,
    parameter int DMG_W        = 8,
    parameter int REGEN_PERIOD = 65_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             restart,
    input  logic             hit_our_req,
    input  logic [DMG_W-1:0] hit_our_dmg,
    output logic             hit_our_ack,
    input  logic             hit_enemy_req,
    input  logic [DMG_W-1:0] hit_enemy_dmg,
    output logic             hit_enemy_ack,
    output logic [7:0]       HP_our_state,
    output logic [7:0]       HP_enemy_state,
    output logic [1:0]       game_end,
    output logic             game_active
);
    localparam int         CW         = (DMG_W > 8) ? DMG_W : 8;
    localparam logic [7:0] HP_INIT    = 8'(HP_MAX);
    localparam logic       SIDE_OUR   = 1'b0;
    localparam logic       SIDE_ENEMY = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_APPLY, S_END} state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [DMG_W-1:0] dmg_q, dmg_d;
    logic             rr_last_q, rr_last_d;
    logic [7:0]       hp_our_q, hp_our_d, hp_enemy_q, hp_enemy_d;
    logic [1:0]       game_end_q, game_end_d;
    logic             ack_our_q, ack_our_d, ack_enemy_q, ack_enemy_d;
    logic             active_q, active_d;

    logic             any_req, both_req, pick_enemy, drain_ok;
    logic [7:0]       tgt_hp, hp_after;
    logic [CW-1:0]    dmg_ext, tgt_ext;

    assign any_req    = hit_our_req | hit_enemy_req;
    assign both_req   = hit_our_req & hit_enemy_req;
    assign pick_enemy = both_req ? (rr_last_q == SIDE_OUR) : hit_enemy_req;
    // In END the requester still holds req during its ack cycle; skip that cycle to avoid a double ack.
    assign drain_ok   = ~ack_our_q & ~ack_enemy_q & ~restart;

    always_comb begin
        tgt_hp   = (grant_q == SIDE_ENEMY) ? hp_enemy_q : hp_our_q;
        dmg_ext  = CW'(dmg_q);
        tgt_ext  = CW'(tgt_hp);
        hp_after = (dmg_ext >= tgt_ext) ? 8'd0 : tgt_hp - 8'(dmg_ext);
    end

`ifdef HP_REGEN_EN
    localparam int CNT_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    logic [CNT_W-1:0] regen_cnt_q, regen_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= SIDE_OUR;
            dmg_q       <= '0;
            rr_last_q   <= SIDE_ENEMY;
            hp_our_q    <= HP_INIT;
            hp_enemy_q  <= HP_INIT;
            game_end_q  <= 2'd0;
            ack_our_q   <= 1'b0;
            ack_enemy_q <= 1'b0;
            active_q    <= 1'b0;
`ifdef HP_REGEN_EN
            regen_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            dmg_q       <= dmg_d;
            rr_last_q   <= rr_last_d;
            hp_our_q    <= hp_our_d;
            hp_enemy_q  <= hp_enemy_d;
            game_end_q  <= game_end_d;
            ack_our_q   <= ack_our_d;
            ack_enemy_q <= ack_enemy_d;
            active_q    <= active_d;
`ifdef HP_REGEN_EN
            regen_cnt_q <= regen_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PLAY;
            S_PLAY:  if (any_req) state_d = S_APPLY;
            S_APPLY: state_d = (hp_after == 8'd0) ? S_END : S_PLAY;
            S_END:   if (restart) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        dmg_d       = dmg_q;
        rr_last_d   = rr_last_q;
        hp_our_d    = hp_our_q;
        hp_enemy_d  = hp_enemy_q;
        game_end_d  = game_end_q;
        ack_our_d   = 1'b0;
        ack_enemy_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                hp_our_d   = HP_INIT;
                hp_enemy_d = HP_INIT;
                game_end_d = 2'd0;
            end
            S_PLAY: if (any_req) begin
                grant_d     = pick_enemy;
                dmg_d       = pick_enemy ? hit_enemy_dmg : hit_our_dmg;
                ack_our_d   = ~pick_enemy;
                ack_enemy_d = pick_enemy;
                if (both_req) rr_last_d = pick_enemy;
            end
            S_APPLY: begin
                if (grant_q == SIDE_ENEMY) hp_enemy_d = hp_after;
                else                       hp_our_d   = hp_after;
                if (hp_after == 8'd0) game_end_d = (grant_q == SIDE_ENEMY) ? 2'd1 : 2'd2;
            end
            S_END: begin
                if (any_req && drain_ok) begin
                    ack_our_d   = ~pick_enemy;
                    ack_enemy_d = pick_enemy;
                    if (both_req) rr_last_d = pick_enemy;
                end
                if (restart) begin
                    hp_our_d   = HP_INIT;
                    hp_enemy_d = HP_INIT;
                    game_end_d = 2'd0;
                end
            end
            default: ;
        endcase
`ifdef HP_REGEN_EN
        // A damage apply to our side clears the count, so a coincident tick is lost.
        regen_cnt_d = '0;
        if (state_q == S_PLAY || (state_q == S_APPLY && grant_q == SIDE_ENEMY)) begin
            if (regen_cnt_q == CNT_W'(REGEN_PERIOD - 1)) begin
                if (hp_our_q < HP_INIT) hp_our_d = hp_our_q + 8'd1;
            end else begin
                regen_cnt_d = regen_cnt_q + CNT_W'(1);
            end
        end
`endif
        active_d = (state_d == S_PLAY) || (state_d == S_APPLY);
    end

    assign hit_our_ack    = ack_our_q;
    assign hit_enemy_ack  = ack_enemy_q;
    assign HP_our_state   = hp_our_q;
    assign HP_enemy_state = hp_enemy_q;
    assign game_end       = game_end_q;
    assign game_active    = active_q;
endmodule
